// File: rtl/mem_port_responder_pkg.sv
// Shared types and helpers for the memory-port responder: FSM states,
// access-direction encoding and byte-address to word-index conversion.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    // Widest byte address handled; narrower ports are zero-extended first.
    localparam int MAX_ADDR_W = 64;
    localparam int CNT_W      = 4;

    function automatic logic [MAX_ADDR_W-3:0] word_index(input logic [MAX_ADDR_W-1:0] addr);
        return addr[MAX_ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/mem_port_responder_ram.sv
// Single-port word RAM with a registered (one-cycle) read and no reset;
// contents survive a responder reset.
module sync_word_ram #(
    parameter  int DEPTH  = 256,
    parameter  int DATA_W = 32,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_port_responder.sv
// Memory-side responder: one request at a time, served from a word RAM after
// a fixed LATENCY, with misaligned / out-of-range accesses flagged as errors.
//
//  state | meaning
//  IDLE  | req_ready high, waiting for req_valid
//  WAIT  | request captured, down-counter running; RAM accessed when it hits 0
//  RESP  | one-cycle rsp_valid with rdata / error
module mem_port_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              busy
);

    localparam int                     RAM_AW    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]       CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [MAX_ADDR_W-3:0]  DEPTH_IDX = (MAX_ADDR_W-2)'(DEPTH);

    resp_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic [RAM_AW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_error_q, rsp_error_d;
    logic                ready_q, ready_d;

    logic [MAX_ADDR_W-3:0] accept_idx;
    logic                  accept_err;
    logic                  last_wait;
    logic                  ram_we, ram_re;
    logic [DATA_W-1:0]     ram_rdata;
    logic [DATA_W-1:0]     resp_rdata;

    assign accept_idx = word_index(MAX_ADDR_W'(req_addr));
    assign accept_err = (req_addr[1:0] != 2'b00) || (accept_idx >= DEPTH_IDX);

    assign last_wait = (state_q == WAIT) && (cnt_q == '0);
    // A reset landing on the write edge must abort the write as well.
    assign ram_we = last_wait && (write_q == MEM_WRITE) && !err_q && !reset;
    assign ram_re = last_wait && (write_q == MEM_READ) && !err_q;

    sync_word_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign resp_rdata = ((write_q == MEM_READ) && !err_q) ? ram_rdata : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                    write_d = req_write;
                    err_d   = accept_err;
                    idx_d   = accept_idx[RAM_AW-1:0];
                    wdata_d = req_wdata;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                hold_d  = resp_rdata;
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
        rsp_error_d = (state_d == RESP) && err_q;
        ready_d     = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            write_q     <= MEM_READ;
            err_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            hold_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            hold_q      <= hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            ready_q     <= ready_d;
        end
    end

    // RAM output is already registered; outside RESP the last response is held.
    assign rsp_rdata = (state_q == RESP) ? resp_rdata : hold_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign req_ready = ready_q;
    assign busy      = !ready_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Randomized bench for mem_port_responder: three instances (LATENCY 2, 1, 4)
// checked against a word-array reference model of the access rules.
`timescale 1ns/1ps
module tb_mem_port_responder;

    localparam int NWORDS = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid_a [3];
    logic        req_write_a [3];
    logic [31:0] req_addr_a  [3];
    logic [31:0] req_wdata_a [3];
    logic        req_ready_a [3];
    logic        rsp_valid_a [3];
    logic [31:0] rsp_rdata_a [3];
    logic        rsp_error_a [3];
    logic        busy_a      [3];

    logic [31:0] ref_mem [3][NWORDS];
    int n_chk = 0;
    int n_bad = 0;

    mem_port_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(NWORDS), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_write(req_write_a[0]),
        .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]),
        .rsp_valid(rsp_valid_a[0]), .rsp_rdata(rsp_rdata_a[0]), .rsp_error(rsp_error_a[0]),
        .busy(busy_a[0]));

    mem_port_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(NWORDS), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_write(req_write_a[1]),
        .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]),
        .rsp_valid(rsp_valid_a[1]), .rsp_rdata(rsp_rdata_a[1]), .rsp_error(rsp_error_a[1]),
        .busy(busy_a[1]));

    mem_port_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(NWORDS), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]), .req_write(req_write_a[2]),
        .req_addr(req_addr_a[2]), .req_wdata(req_wdata_a[2]),
        .rsp_valid(rsp_valid_a[2]), .rsp_rdata(rsp_rdata_a[2]), .rsp_error(rsp_error_a[2]),
        .busy(busy_a[2]));

    function automatic int lat_of(input int u);
        case (u)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction on instance u. While the request is in flight the inputs
    // are scrambled and req_valid is optionally held high with a junk write.
    task automatic do_req(input int u, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit junk,
                          input logic [31:0] junk_addr, input logic [31:0] junk_data);
        int          waited;
        int          lat;
        bit          err;
        int          idx;
        logic [31:0] exp_rd;

        @(negedge clk);
        req_valid_a[u] = 1'b1;
        req_write_a[u] = wr;
        req_addr_a[u]  = addr;
        req_wdata_a[u] = wdata;
        waited = 0;
        while (req_ready_a[u] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            chk_eq("accept_timeout", 32'd0, 32'd1);
            req_valid_a[u] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid_a[u] = junk;
        req_write_a[u] = 1'b1;
        req_addr_a[u]  = junk_addr;
        req_wdata_a[u] = junk_data;

        idx = int'(addr >> 2);
        err = (addr[1:0] != 2'b00) || (addr >= 32'(NWORDS * 4));
        exp_rd = 32'd0;
        if (!err && wr) ref_mem[u][idx] = wdata;
        if (!err && !wr) exp_rd = ref_mem[u][idx];

        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid_a[u] === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk_eq("latency", 32'(lat), 32'(lat_of(u)));
        chk_eq("rsp_error", 32'(rsp_error_a[u]), 32'(err));
        chk_eq("rsp_rdata", rsp_rdata_a[u], exp_rd);
        chk_eq("ready_in_resp", 32'(req_ready_a[u]), 32'd0);

        @(posedge clk);
        #1;
        req_valid_a[u] = 1'b0;
        chk_eq("ready_after_resp", 32'(req_ready_a[u]), 32'd1);
        chk_eq("valid_one_cycle", 32'(rsp_valid_a[u]), 32'd0);
        chk_eq("busy_after_resp", 32'(busy_a[u]), 32'd0);
        chk_eq("rdata_hold", rsp_rdata_a[u], exp_rd);
    endtask

    // Accept a write on instance u, then pulse reset while it is still in WAIT.
    task automatic reset_mid_write(input int u, input logic [31:0] addr, input logic [31:0] wdata);
        int waited;
        @(negedge clk);
        req_valid_a[u] = 1'b1;
        req_write_a[u] = 1'b1;
        req_addr_a[u]  = addr;
        req_wdata_a[u] = wdata;
        waited = 0;
        while (req_ready_a[u] !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        req_valid_a[u] = 1'b0;
        chk_eq("busy_before_reset", 32'(busy_a[u]), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("rst_valid", 32'(rsp_valid_a[u]), 32'd0);
        chk_eq("rst_ready", 32'(req_ready_a[u]), 32'd1);
        chk_eq("rst_busy", 32'(busy_a[u]), 32'd0);
        chk_eq("rst_error", 32'(rsp_error_a[u]), 32'd0);
        chk_eq("rst_rdata", rsp_rdata_a[u], 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk_eq("no_rsp_after_reset", 32'(rsp_valid_a[u]), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            req_valid_a[u] = 1'b0;
            req_write_a[u] = 1'b0;
            req_addr_a[u]  = 32'd0;
            req_wdata_a[u] = 32'd0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 3; u++) begin
                chk_eq("idle_ready", 32'(req_ready_a[u]), 32'd1);
                chk_eq("idle_valid", 32'(rsp_valid_a[u]), 32'd0);
                chk_eq("idle_rdata", rsp_rdata_a[u], 32'd0);
            end
        end

        // Fill every word so no read ever sees an uninitialised location.
        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < NWORDS; i++) begin
                do_req(u, 1'b1, 32'(i * 4), $urandom, 1'b0, 32'd0, 32'd0);
            end
        end

        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0);
        do_req(0, 1'b0, 32'h10, 32'd0, 1'b0, 32'd0, 32'd0);
        do_req(0, 1'b0, 32'h13, 32'd0, 1'b0, 32'd0, 32'd0);
        do_req(0, 1'b1, 32'h400, 32'hCAFEF00D, 1'b0, 32'd0, 32'd0);
        do_req(0, 1'b0, 32'h0, 32'd0, 1'b0, 32'd0, 32'd0);

        do_req(0, 1'b0, 32'h24, 32'd0, 1'b1, 32'h20, 32'h1);
        do_req(0, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0, 32'd0);

        reset_mid_write(0, 32'h8, 32'h55);
        do_req(0, 1'b0, 32'h8, 32'd0, 1'b0, 32'd0, 32'd0);
        reset_mid_write(1, 32'hC, 32'h66);
        do_req(1, 1'b0, 32'hC, 32'd0, 1'b0, 32'd0, 32'd0);

        for (int u = 1; u < 3; u++) begin
            for (int i = 0; i < 8; i++) begin
                do_req(u, 1'b0, 32'($urandom_range(0, NWORDS - 1) * 4), 32'd0, 1'b0, 32'd0, 32'd0);
            end
        end

        for (int u = 0; u < 3; u++) begin
            for (int i = 0; i < 60; i++) begin
                logic [31:0] a;
                int          sel;
                sel = $urandom_range(0, 9);
                if (sel < 7)       a = 32'($urandom_range(0, 15) * 4);
                else if (sel == 7) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
                else if (sel == 8) a = 32'h400 + 32'($urandom_range(0, 63) * 4);
                else               a = $urandom;
                do_req(u, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)),
                       32'($urandom_range(0, 15) * 4), $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
